// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin shared 64-bit ALU with registered result, flags and saturating grant counters
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int M = WIDTH - 1;
  logic             last_grant;
  logic             load;
  logic [1:0]       xfer;
  logic             sel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             of;
  always_comb begin
    load      = ~out_valid | out_ready;
    req_ready = ~load ? 2'b00 : &req_valid ? (last_grant ? 2'b01 : 2'b10) : req_valid;
    xfer      = req_valid & req_ready;
    sel       = req_ready[1];
    op        = sel ? req1_op : req0_op;
    a         = sel ? req1_a : req0_a;
    b         = sel ? req1_b : req0_b;
    res       = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a ^ b;
    of        = op == 2'd0 ? (a[M] == b[M]) & (res[M] != a[M]) :
                op == 2'd1 ? (a[M] != b[M]) & (res[M] != a[M]) : 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
      out_res    <= '0;
      out_zf     <= 1'b0;
      out_sf     <= 1'b0;
      out_of     <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      last_grant <= 1'b1;
    end else if (|xfer) begin
      out_valid  <= 1'b1;
      out_id     <= xfer[1];
      out_res    <= res;
      out_zf     <= res == '0;
      out_sf     <= res[M];
      out_of     <= of;
      last_grant <= xfer[1];
      cnt0       <= cnt0 + {{(CNT_W-1){1'b0}}, xfer[0] & ~&cnt0};
      cnt1       <= cnt1 + {{(CNT_W-1){1'b0}}, xfer[1] & ~&cnt1};
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks against a behavioural model of the shared ALU
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready, u2_req_ready;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        out_valid, out_id, out_zf, out_sf, out_of;
  logic        out_ready = 1'b0;
  logic [63:0] out_res;
  logic [15:0] cnt0, cnt1;
  logic        u2_valid, u2_id, u2_zf, u2_sf, u2_of;
  logic [63:0] u2_res;
  logic [1:0]  u2_cnt0, u2_cnt1;
  int total = 0;
  int bad = 0;
  logic        mv, mid, mzf, msf, mof, ml;
  logic [63:0] mres;
  int          mcnt[2];
  logic [63:0] sr;
  logic        si;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_res(out_res),
    .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_share_arbiter #(.WIDTH(64), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(u2_req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .out_valid(u2_valid), .out_ready(out_ready), .out_id(u2_id), .out_res(u2_res),
    .out_zf(u2_zf), .out_sf(u2_sf), .out_of(u2_of), .cnt0(u2_cnt0), .cnt1(u2_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return v > m ? m : v;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h0;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_reset();
    mv = 0; mid = 0; mres = '0; mzf = 0; msf = 0; mof = 0; ml = 1;
    mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_res", out_res, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle();
    int g;
    logic [1:0] erdy, op;
    logic [63:0] a, b;
    logic [64:0] s;
    g = -1;
    if (!mv || out_ready) begin
      if (req_valid == 2'b01) g = 0;
      else if (req_valid == 2'b10) g = 1;
      else if (req_valid == 2'b11) g = ml ? 0 : 1;
    end
    erdy = 2'b00;
    if (g >= 0) erdy[g] = 1'b1;
    @(negedge clk);
    chk("req_ready", req_ready, erdy);
    chk("out_valid", out_valid, mv);
    chk("out_id", out_id, mid);
    chk("out_res", out_res, mres);
    chk("flags", {out_zf, out_sf, out_of}, {mzf, msf, mof});
    chk("cnt0", cnt0, sat(mcnt[0], 65535));
    chk("cnt1", cnt1, sat(mcnt[1], 65535));
    chk("sat_cnt0", u2_cnt0, sat(mcnt[0], 3));
    chk("sat_cnt1", u2_cnt1, sat(mcnt[1], 3));
    @(posedge clk);
    if (g >= 0) begin
      op = g == 1 ? req1_op : req0_op;
      a  = g == 1 ? req1_a : req0_a;
      b  = g == 1 ? req1_b : req0_b;
      mof = 0;
      case (op)
        2'd0: begin s = {a[63], a} + {b[63], b}; mres = s[63:0]; mof = s[64] != s[63]; end
        2'd1: begin s = {a[63], a} - {b[63], b}; mres = s[63:0]; mof = s[64] != s[63]; end
        2'd2: mres = a & b;
        default: mres = a ^ b;
      endcase
      mzf = mres == 0;
      msf = mres[63];
      mv = 1;
      mid = g[0];
      ml = g[0];
      mcnt[g]++;
    end else if (out_ready) begin
      mv = 0;
    end
    #1;
  endtask

  initial begin
    do_reset();
    out_ready = 1'b1;
    req_valid = 2'b01; req0_op = 2'd2; req0_a = 64'hAAAA; req0_b = 64'h5555;
    cycle();
    chk("and_res", out_res, 0);
    chk("and_flags", {out_zf, out_sf, out_of}, 3'b100);
    chk("and_id", out_id, 0);
    chk("and_cnt0", cnt0, 1);
    #2;
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req0_op = 2'($urandom); req0_a = rnd64(); req0_b = rnd64();
      req1_op = 2'($urandom); req1_a = rnd64(); req1_b = rnd64();
      cycle();
      chk("rr_id", out_id, 64'(i % 2));
    end
    chk("rr_cnt0", cnt0, 3);
    chk("rr_cnt1", cnt1, 3);
    out_ready = 1'b0;
    sr = out_res;
    si = out_id;
    for (int i = 0; i < 3; i++) begin
      req0_a = rnd64(); req1_a = rnd64();
      cycle();
      chk("hold_res", out_res, sr);
      chk("hold_id", out_id, si);
      chk("hold_rdy", req_ready, 0);
    end
    out_ready = 1'b1;
    cycle();
    chk("drain_valid", out_valid, 1);
    chk("drain_id", out_id, 0);
    chk("drain_cnt0", cnt0, 4);
    req_valid = 2'b01;
    req0_op = 2'd0; req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'h1;
    cycle();
    chk("add_res", out_res, 64'h8000_0000_0000_0000);
    chk("add_flags", {out_zf, out_sf, out_of}, 3'b011);
    req0_op = 2'd1; req0_a = 64'h0; req0_b = 64'h1;
    cycle();
    chk("sub_res", out_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_flags", {out_zf, out_sf, out_of}, 3'b010);
    req0_op = 2'd3; req0_a = 64'h1234_5678_9ABC_DEF0; req0_b = 64'h1234_5678_9ABC_DEF0;
    cycle();
    chk("xor_res", out_res, 0);
    chk("xor_flags", {out_zf, out_sf, out_of}, 3'b100);
    do_reset();
    req_valid = 2'b10; req1_op = 2'd0;
    for (int i = 1; i <= 5; i++) begin
      req1_a = rnd64(); req1_b = rnd64();
      cycle();
      chk("sat_seq", u2_cnt1, 64'(i > 3 ? 3 : i));
    end
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      req0_op = 2'($urandom); req0_a = rnd64(); req0_b = $urandom_range(0, 4) == 0 ? req0_a : rnd64();
      req1_op = 2'($urandom); req1_a = rnd64(); req1_b = $urandom_range(0, 4) == 0 ? req1_a : rnd64();
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset();
      end
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
